// File: rtl/map_port_arbiter.sv
// Round-robin arbiter and read-modify-write sequencer for port B of the 30x160 map RAM.
// Each granted request replaces one 4-bit tile nibble in a row and reports the code it overwrote.
module map_port_arbiter #(
  parameter int N_REQ      = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [6*N_REQ-1:0]   req_x,
  input  logic [5*N_REQ-1:0]   req_y,
  input  logic [4*N_REQ-1:0]   req_tile,
  output logic [N_REQ-1:0]     ack,
  output logic [3:0]           ack_old_tile,
  output logic                 ack_err,
  output logic                 busy,
  output logic [4:0]           ram_addr,
  output logic [159:0]         ram_wrdata,
  output logic                 ram_wren,
  input  logic [159:0]         ram_rddata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_ACK} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_gnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [5:0]         r_x;
  logic [4:0]         r_y;
  logic [3:0]         r_tile;

  logic               w_gnt_vld;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [5:0]         w_x;
  logic [4:0]         w_y;
  logic [3:0]         w_tile;
  logic               w_oor;

  // Column 0 is the most significant nibble of the row.
  function automatic logic [7:0] nib_pos(input logic [5:0] x);
    logic [7:0] pos;
    pos = 8'd156 - {x, 2'b00};
    if (x > 6'd39) pos = 8'd0;
    return pos;
  endfunction

  function automatic logic [3:0] get_nib(input logic [159:0] row, input logic [5:0] x);
    return row[nib_pos(x) +: 4];
  endfunction

  function automatic logic [159:0] put_nib(input logic [159:0] row, input logic [5:0] x,
                                           input logic [3:0] tile);
    logic [159:0] res;
    res = row;
    res[nib_pos(x) +: 4] = tile;
    return res;
  endfunction

  // Round-robin search starting just after the last granted index.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_gnt_vld && req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_x    = '0;
    w_y    = '0;
    w_tile = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) begin
        w_x    = req_x[6*i +: 6];
        w_y    = req_y[5*i +: 5];
        w_tile = req_tile[4*i +: 4];
      end
    end
    w_oor = (w_x > 6'd39) || (w_y > 5'd29);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_state_nxt = w_oor ? S_ACK : S_READ;
      S_READ:  if (r_cnt == '0) w_state_nxt = S_MERGE;
      S_MERGE: w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_last       <= IDX_W'(N_REQ - 1);
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_tile       <= '0;
      ack          <= '0;
      ack_old_tile <= '0;
      ack_err      <= 1'b0;
      busy         <= 1'b0;
      ram_addr     <= '0;
      ram_wrdata   <= '0;
      ram_wren     <= 1'b0;
    end else begin
      busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt  <= w_gnt_idx;
            r_last <= w_gnt_idx;
            r_x    <= w_x;
            r_y    <= w_y;
            r_tile <= w_tile;
            if (w_oor) begin
              ack          <= N_REQ'(1) << w_gnt_idx;
              ack_err      <= 1'b1;
              ack_old_tile <= '0;
            end else begin
              ram_addr <= w_y;
              r_cnt    <= CNT_W'(RD_LATENCY - 1);
            end
          end
        end
        S_READ: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        // Read data lands this cycle; the merged row becomes the write data.
        S_MERGE: begin
          ram_wrdata   <= put_nib(ram_rddata, r_x, r_tile);
          ack_old_tile <= get_nib(ram_rddata, r_x);
          ram_wren     <= 1'b1;
        end
        S_WRITE: begin
          ram_wren <= 1'b0;
          ack      <= N_REQ'(1) << r_gnt;
          ack_err  <= 1'b0;
        end
        S_ACK: begin
          ack     <= '0;
          ack_err <= 1'b0;
        end
        default: begin
          ram_wren <= 1'b0;
          ack      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter: single updates, arbitration order, range errors,
// same-row back-to-back updates and reset during READ on a slower-RAM instance.
module tb_map_port_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           reset;
  logic [N-1:0]   req;
  logic [6*N-1:0] req_x;
  logic [5*N-1:0] req_y;
  logic [4*N-1:0] req_tile;
  logic [N-1:0]   ack;
  logic [3:0]     ack_old_tile;
  logic           ack_err, busy, ram_wren;
  logic [4:0]     ram_addr;
  logic [159:0]   ram_wrdata, ram_rddata;

  logic           reset3;
  logic [N-1:0]   req3;
  logic [6*N-1:0] req_x3;
  logic [5*N-1:0] req_y3;
  logic [4*N-1:0] req_tile3;
  logic [N-1:0]   ack3;
  logic [3:0]     old3;
  logic           err3, busy3, wren3;
  logic [4:0]     addr3;
  logic [159:0]   wrdata3, rd3, p3_0, p3_1;

  map_port_arbiter #(.N_REQ(N), .RD_LATENCY(1)) u_dut (
    .CLOCK_50(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_tile(req_tile), .ack(ack), .ack_old_tile(ack_old_tile), .ack_err(ack_err),
    .busy(busy), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wren(ram_wren),
    .ram_rddata(ram_rddata));

  map_port_arbiter #(.N_REQ(N), .RD_LATENCY(3)) u_dut3 (
    .CLOCK_50(clk), .reset(reset3), .req(req3), .req_x(req_x3), .req_y(req_y3),
    .req_tile(req_tile3), .ack(ack3), .ack_old_tile(old3), .ack_err(err3),
    .busy(busy3), .ram_addr(addr3), .ram_wrdata(wrdata3), .ram_wren(wren3),
    .ram_rddata(rd3));

  logic [159:0] mem  [0:31];
  logic [159:0] mem3 [0:31];
  logic         pre_en;
  logic [4:0]   pre_addr;
  logic [159:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_addr] <= ram_wrdata;
    ram_rddata <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (pre_en) mem3[pre_addr] <= pre_data;
    else if (wren3) mem3[addr3] <= wrdata3;
    p3_0 <= mem3[addr3];
    p3_1 <= p3_0;
    rd3  <= p3_1;
  end

  int wren3_cnt = 0;
  int ack3_cnt  = 0;
  always @(negedge clk) begin
    if (wren3 === 1'b1) wren3_cnt++;
    if (ack3 !== '0 && ack3 !== 'x) ack3_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] base(input int y);
    return {5{32'hA5C3_0F1E ^ y}};
  endfunction

  function automatic logic [159:0] set_nib(input logic [159:0] r, input int x, input logic [3:0] t);
    logic [159:0] o;
    o = r;
    o[156-4*x +: 4] = t;
    return o;
  endfunction

  task automatic preload(input logic [4:0] a, input logic [159:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int         idx;
    int         x;
    int         y;
    logic [3:0] tile;
    logic [3:0] old;
    logic       err;
  } vec_t;

  vec_t         vecs [7];
  logic [159:0] last_wdat, last_row0;

  task automatic run_one(input vec_t v, input string nm);
    logic [159:0] row0, exp_row, wdat;
    logic [N-1:0] ackv;
    logic [3:0]   old;
    logic         err;
    int           c0, wcyc, acyc, nw;
    row0 = '0; exp_row = '0; wdat = '0; ackv = '0; old = '0; err = 1'b0;
    if (!v.err) begin
      row0    = set_nib(base(v.y), v.x, v.old);
      preload(5'(v.y), row0);
      exp_row = set_nib(row0, v.x, v.tile);
    end
    req = '0;
    req_x[6*v.idx +: 6]    = 6'(v.x);
    req_y[5*v.idx +: 5]    = 5'(v.y);
    req_tile[4*v.idx +: 4] = v.tile;
    req[v.idx] = 1'b1;
    c0 = cyc; wcyc = -1; acyc = -1; nw = 0;
    for (int k = 0; k < 20 && acyc < 0; k++) begin
      @(negedge clk);
      if (ram_wren) begin nw++; wcyc = cyc - c0; wdat = ram_wrdata; end
      if (ack != '0) begin
        acyc = cyc - c0; ackv = ack; old = ack_old_tile; err = ack_err; req = '0;
      end
    end
    req = '0;
    @(negedge clk);
    chk({nm, "_ack_cycle"}, 160'(acyc), v.err ? 160'(1) : 160'(4));
    chk({nm, "_ack_vec"}, 160'(ackv), 160'(N'(1) << v.idx));
    chk({nm, "_ack_err"}, 160'(err), 160'(v.err));
    chk({nm, "_old_tile"}, 160'(old), v.err ? 160'(0) : 160'(v.old));
    chk({nm, "_wren_count"}, 160'(nw), v.err ? 160'(0) : 160'(1));
    chk({nm, "_busy_after"}, 160'(busy), 160'(0));
    if (!v.err) begin
      chk({nm, "_wren_cycle"}, 160'(wcyc), 160'(3));
      chk({nm, "_wrdata"}, wdat, exp_row);
      chk({nm, "_ram_row"}, mem[v.y], exp_row);
    end
    last_wdat = wdat;
    last_row0 = row0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] ord [3];
    int           ac  [3];
    int           c0, nack;
    logic [159:0] exp7;

    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    req = '0; req_x = '0; req_y = '0; req_tile = '0;
    req3 = '0; req_x3 = '0; req_y3 = '0; req_tile3 = '0;
    reset = 1'b1; reset3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 160'(ack), 160'(0));
    chk("rst_ack_err", 160'(ack_err), 160'(0));
    chk("rst_old_tile", 160'(ack_old_tile), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_ram_addr", 160'(ram_addr), 160'(0));
    chk("rst_ram_wrdata", ram_wrdata, 160'(0));
    chk("rst_ram_wren", 160'(ram_wren), 160'(0));
    reset = 1'b0; reset3 = 1'b0;
    @(negedge clk);

    vecs[0] = '{0, 10,  5, 4'h7, 4'h2, 1'b0};
    vecs[1] = '{1,  0, 29, 4'h9, 4'h3, 1'b0};
    vecs[2] = '{2, 39, 29, 4'hC, 4'h5, 1'b0};
    vecs[3] = '{0, 40,  0, 4'h1, 4'h0, 1'b1};
    vecs[4] = '{1,  5, 30, 4'h2, 4'h0, 1'b1};
    vecs[5] = '{2, 20, 12, 4'h4, 4'h4, 1'b0};
    vecs[6] = '{1, 63, 31, 4'hE, 4'h0, 1'b1};

    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) chk("col10_nibble", 160'(last_wdat[119:116]), 160'(4'h7));
      if (i == 1) begin
        chk("col0_nibble", 160'(last_wdat[159:156]), 160'(4'h9));
        chk("col0_rest", 160'(last_wdat[155:0]), 160'(last_row0[155:0]));
      end
      if (i == 2) begin
        chk("col39_nibble", 160'(last_wdat[3:0]), 160'(4'hC));
        chk("col39_rest", 160'(last_wdat[159:4]), 160'(last_row0[159:4]));
      end
    end

    // All three requesting at once right after reset.
    apply_reset();
    for (int r = 2; r <= 4; r++) preload(5'(r), base(r));
    req_x = {6'd3, 6'd2, 6'd1};
    req_y = {5'd4, 5'd3, 5'd2};
    req_tile = {4'h3, 4'h2, 4'h1};
    req = 3'b111;
    c0 = cyc; nack = 0;
    for (int j = 0; j < 3; j++) begin ord[j] = '0; ac[j] = -1; end
    for (int k = 0; k < 40 && nack < 3; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        ord[nack] = ack; ac[nack] = cyc - c0; nack++; req = req & ~ack;
      end
    end
    req = '0;
    @(negedge clk);
    chk("sim_ack_count", 160'(nack), 160'(3));
    chk("sim_order0", 160'(ord[0]), 160'(3'b001));
    chk("sim_order1", 160'(ord[1]), 160'(3'b010));
    chk("sim_order2", 160'(ord[2]), 160'(3'b100));
    chk("sim_cycle0", 160'(ac[0]), 160'(4));
    chk("sim_cycle1", 160'(ac[1]), 160'(9));
    chk("sim_cycle2", 160'(ac[2]), 160'(14));
    chk("sim_row2", mem[2], set_nib(base(2), 1, 4'h1));
    chk("sim_row3", mem[3], set_nib(base(3), 2, 4'h2));
    chk("sim_row4", mem[4], set_nib(base(4), 3, 4'h3));

    // Requester 0 holds req; requester 1 joins at cycle 2 and must not starve.
    apply_reset();
    preload(5'd8, base(8));
    preload(5'd9, base(9));
    req_x = '0; req_y = '0; req_tile = '0;
    req_x[5:0] = 6'd6; req_y[4:0] = 5'd8; req_tile[3:0] = 4'h5;
    req = 3'b001;
    c0 = cyc; nack = 0;
    for (int j = 0; j < 3; j++) begin ord[j] = '0; ac[j] = -1; end
    for (int k = 0; k < 40 && nack < 3; k++) begin
      @(negedge clk);
      if (cyc - c0 == 2) begin
        req_x[11:6] = 6'd7; req_y[9:5] = 5'd9; req_tile[7:4] = 4'h6; req[1] = 1'b1;
      end
      if (ack != '0) begin
        ord[nack] = ack; ac[nack] = cyc - c0; nack++;
        if (ack[1]) req[1] = 1'b0;
        if (nack == 3) req = '0;
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
    chk("fair_ack_count", 160'(nack), 160'(3));
    chk("fair_order0", 160'(ord[0]), 160'(3'b001));
    chk("fair_order1", 160'(ord[1]), 160'(3'b010));
    chk("fair_order2", 160'(ord[2]), 160'(3'b001));
    chk("fair_cycle2", 160'(ac[2]), 160'(14));
    chk("fair_row9", mem[9], set_nib(base(9), 7, 4'h6));
    chk("fair_busy_end", 160'(busy), 160'(0));

    // Two updates to the same row must both survive.
    preload(5'd7, base(7));
    req_x = {6'd0, 6'd4, 6'd3};
    req_y = {5'd0, 5'd7, 5'd7};
    req_tile = {4'h0, 4'hB, 4'hA};
    req = 3'b011;
    nack = 0;
    for (int k = 0; k < 40 && nack < 2; k++) begin
      @(negedge clk);
      if (ack != '0) begin nack++; req = req & ~ack; end
    end
    req = '0;
    @(negedge clk);
    exp7 = set_nib(set_nib(base(7), 3, 4'hA), 4, 4'hB);
    chk("b2b_ack_count", 160'(nack), 160'(2));
    chk("b2b_row7", mem[7], exp7);
    chk("b2b_nib_col3", 160'(mem[7][147:144]), 160'(4'hA));
    chk("b2b_nib_col4", 160'(mem[7][143:140]), 160'(4'hB));

    // Reset while the slow-RAM instance sits in READ.
    preload(5'd1, base(1));
    req_x3[5:0] = 6'd2; req_y3[4:0] = 5'd1; req_tile3[3:0] = 4'hF;
    req3 = 3'b001;
    repeat (2) @(negedge clk);
    chk("rd3_busy_in_read", 160'(busy3), 160'(1));
    reset3 = 1'b1;
    req3 = '0;
    @(negedge clk);
    chk("rd3_busy_after_rst", 160'(busy3), 160'(0));
    chk("rd3_ack_after_rst", 160'(ack3), 160'(0));
    chk("rd3_wren_after_rst", 160'(wren3), 160'(0));
    chk("rd3_addr_after_rst", 160'(addr3), 160'(0));
    reset3 = 1'b0;
    repeat (8) @(negedge clk);
    chk("rd3_wren_count", 160'(wren3_cnt), 160'(0));
    chk("rd3_ack_count", 160'(ack3_cnt), 160'(0));
    chk("rd3_ram_unchanged", mem3[1], base(1));
    chk("rd3_busy_idle", 160'(busy3), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
